// File: rtl/aes_pkg.sv
// Shared AES sequencing types: key length, round type, FSM states and the
// number-of-rounds helper.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'd0,
    KL_192  = 2'd1,
    KL_256  = 2'd2,
    KL_256B = 2'd3
  } keylen_t;

  typedef enum logic [1:0] {
    RT_INIT  = 2'd0,
    RT_FULL  = 2'd1,
    RT_FINAL = 2'd2,
    RT_RSVD  = 2'd3
  } rnd_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEXP  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Both 256-bit encodings share one schedule length.
  function automatic logic [3:0] nr_of(input keylen_t keylen);
    case (keylen)
      KL_128:  nr_of = NR_128;
      KL_192:  nr_of = NR_192;
      default: nr_of = NR_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Job, key-expansion, round-command and result signals between the AES top,
// the round sequencer and the shared round engine.
interface aes_round_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [1:0] in_keylen;
  logic       in_key_new;
  logic       key_load;
  logic       key_ready;
  logic       rnd_en;
  logic [3:0] rnd_idx;
  logic [1:0] rnd_type;
  logic       rnd_inv;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport slave (
    input  in_valid, in_mode, in_keylen, in_key_new, key_ready, out_ready,
    output in_ready, key_load, rnd_en, rnd_idx, rnd_type, rnd_inv, out_valid, busy
  );

  modport master (
    output in_valid, in_mode, in_keylen, in_key_new, key_ready, out_ready,
    input  in_ready, key_load, rnd_en, rnd_idx, rnd_type, rnd_inv, out_valid, busy
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round sequencer: accepts a job, re-expands the key only when
// the cached schedule is unusable, then issues one round command per cycle.
//
// state | meaning
// IDLE  | waiting for a job, in_ready high
// KEXP  | key expansion running; key_load in first cycle, then wait key_ready
// ROUND | round counter k = 0..Nr, one round command per cycle
// DONE  | result valid, held until out_ready
module aes_round_sequencer
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  aes_round_sequencer_if.slave bus
);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  keylen_t    keylen, keylen_nxt;
  logic       mode, mode_nxt;
  logic       cache_valid, cache_valid_nxt;
  logic [3:0] cache_nr, cache_nr_nxt;
  logic [3:0] nr;
  logic       need_kexp;

  assign nr        = nr_of(keylen);
  assign need_kexp = bus.in_key_new | ~cache_valid |
                     (cache_nr != nr_of(keylen_t'(bus.in_keylen)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      keylen      <= KL_128;
      mode        <= 1'b0;
      cache_valid <= 1'b0;
      cache_nr    <= 4'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      keylen      <= keylen_nxt;
      mode        <= mode_nxt;
      cache_valid <= cache_valid_nxt;
      cache_nr    <= cache_nr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    keylen_nxt      = keylen;
    mode_nxt        = mode;
    cache_valid_nxt = cache_valid;
    cache_nr_nxt    = cache_nr;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mode_nxt   = bus.in_mode;
          keylen_nxt = keylen_t'(bus.in_keylen);
          cnt_nxt    = 4'd0;
          state_nxt  = need_kexp ? ST_KEXP : ST_ROUND;
        end
      end
      ST_KEXP: begin
        // cnt marks the key_load cycle; key_ready only counts after it.
        if (cnt == 4'd0) begin
          cnt_nxt = 4'd1;
        end else if (bus.key_ready) begin
          cnt_nxt         = 4'd0;
          state_nxt       = ST_ROUND;
          cache_valid_nxt = 1'b1;
          cache_nr_nxt    = nr;
        end
      end
      ST_ROUND: begin
        if (cnt == nr) begin
          cnt_nxt   = 4'd0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.key_load  = (state == ST_KEXP) && (cnt == 4'd0);
  assign bus.rnd_en    = (state == ST_ROUND);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.rnd_inv   = mode;
  assign bus.rnd_idx   = (state != ST_ROUND) ? 4'd0 :
                         mode ? (nr - cnt) : cnt;
  assign bus.rnd_type  = (state != ST_ROUND) ? 2'(RT_INIT) :
                         (cnt == 4'd0)        ? 2'(RT_INIT) :
                         (cnt == nr)          ? 2'(RT_FINAL) : 2'(RT_FULL);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench for aes_round_sequencer against a job-level model of the
// key cache and round schedule.
module tb_aes_round_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  // model of the key cache
  bit   m_cvalid;
  int   m_cnr;

  aes_round_sequencer_if bus();

  aes_round_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nr_model(input int kl);
    return (kl >= 2) ? 14 : 10 + 2 * kl;
  endfunction

  function automatic logic [11:0] out_vec();
    return {bus.in_ready, bus.key_load, bus.rnd_en, bus.rnd_idx, bus.rnd_type,
            bus.rnd_inv, bus.out_valid, bus.busy};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.in_valid   = 1'($urandom_range(0, 1));
    bus.in_mode    = 1'($urandom_range(0, 1));
    bus.in_keylen  = 2'($urandom_range(0, 3));
    bus.in_key_new = 1'($urandom_range(0, 1));
  endtask

  // Runs one job starting in an IDLE cycle; returns in the following IDLE cycle.
  task automatic run_job(input int mode, input int kl, input int key_new,
                         input int krd, input int hold, input int abort_at);
    int  nr;
    bit  need;
    int  nkexp;
    nr   = nr_model(kl);
    need = (key_new != 0) || !m_cvalid || (m_cnr != nr);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.in_valid   = 1'b1;
    bus.in_mode    = 1'(mode);
    bus.in_keylen  = 2'(kl);
    bus.in_key_new = 1'(key_new);
    bus.key_ready  = 1'($urandom_range(0, 1));
    next_cycle();

    if (need) begin
      nkexp = (krd + 1 > 2) ? krd + 1 : 2;
      for (int i = 1; i <= nkexp; i++) begin
        noise();
        bus.key_ready = (i - 1 >= krd);
        check("kexp_key_load", 32'(bus.key_load), 32'(i == 1));
        check("kexp_rnd_en", 32'(bus.rnd_en), 32'd0);
        check("kexp_busy", 32'(bus.busy), 32'd1);
        next_cycle();
      end
      m_cvalid = 1'b1;
      m_cnr    = nr;
    end

    for (int k = 0; k <= nr; k++) begin
      noise();
      bus.key_ready = 1'($urandom_range(0, 1));
      check("rnd_en", 32'(bus.rnd_en), 32'd1);
      check("rnd_idx", 32'(bus.rnd_idx), 32'((mode != 0) ? nr - k : k));
      check("rnd_type", 32'(bus.rnd_type), 32'((k == 0) ? 0 : (k == nr) ? 2 : 1));
      check("rnd_inv", 32'(bus.rnd_inv), 32'(mode));
      check("rnd_key_load", 32'(bus.key_load), 32'd0);
      check("rnd_in_ready", 32'(bus.in_ready), 32'd0);
      if (k == abort_at) begin
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        m_cvalid = 1'b0;
        check("abort_outputs", 32'(out_vec()), 32'h800);
        return;
      end
      next_cycle();
    end

    for (int w = 0; w <= hold; w++) begin
      noise();
      bus.out_ready = (w == hold);
      check("done_out_valid", 32'(bus.out_valid), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd1);
      check("done_in_ready", 32'(bus.in_ready), 32'd0);
      check("done_rnd_en", 32'(bus.rnd_en), 32'd0);
      check("done_key_load", 32'(bus.key_load), 32'd0);
      next_cycle();
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_cvalid = 1'b0;
    m_cnr = 0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_mode    = 1'b0;
    bus.in_keylen  = 2'd0;
    bus.in_key_new = 1'b0;
    bus.key_ready  = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) next_cycle();
    check("reset_outputs", 32'(out_vec()), 32'h800);
    rst_n = 1'b1;
    next_cycle();
    check("reset_idle", 32'(out_vec()), 32'h800);

    run_job(0, 0, 1, 3, 0, -1);   // AES-128 encrypt, fresh key
    run_job(0, 0, 0, 0, 0, -1);   // cached: out_valid at T+12
    run_job(1, 2, 0, 1, 0, -1);   // 256 forces expansion (Nr differs)
    run_job(1, 3, 0, 0, 0, -1);   // keylen 3 reuses keylen 2 schedule
    run_job(0, 1, 0, 0, 2, -1);   // 192 after 256 cache, key_ready early
    run_job(1, 1, 0, 0, 5, -1);   // consumer stalls 5 cycles
    run_job(0, 2, 0, 2, 0, 4);    // reset during ROUND at k=4
    run_job(0, 2, 0, 1, 0, -1);   // must re-expand after reset

    for (int j = 0; j < 24; j++)
      run_job($urandom_range(0, 1), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 5),
              $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(0, 10) : -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM that drives one iterative AES round datapath plus its key-expansion unit for 128/192/256-bit keys, encrypt or decrypt. Accepts one job per handshake and triggers key expansion only when needed. Issues one round command per cycle (round-key index, round type, direction) and holds the result handshake until the consumer takes it. It sits between the AES top-level and the shared round engine, replacing the fully unrolled encrypt/decrypt instances.

## Interface
- No parameters. Nr is derived from `in_keylen`: 0→10, 1→12, 2 or 3→14.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  job request
- in_ready  out  1  job accepted when `in_valid & in_ready`
- in_mode  in  1  0 = encrypt, 1 = decrypt (inverse cipher)
- in_keylen  in  2  0 = 128, 1 = 192, 2/3 = 256
- in_key_new  in  1  key material changed; force re-expansion
- key_load  out  1  one-cycle pulse that starts the key-expansion unit
- key_ready  in  1  key schedule complete (level)
- rnd_en  out  1  round datapath executes this cycle
- rnd_idx  out  4  round-key index 0..14
- rnd_type  out  2  0 = initial AddRoundKey, 1 = full round, 2 = final round (no MixColumns), 3 unused
- rnd_inv  out  1  inverse round select, registered copy of `in_mode`
- out_valid  out  1  result in datapath state register is valid
- out_ready  in  1  consumer takes result
- busy  out  1  state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE → KEXP on accept when expansion is needed; otherwise IDLE → ROUND.
  - KEXP → ROUND when `key_ready` is seen.
  - ROUND → DONE after the last round.
  - DONE → IDLE on `out_ready`.
- On accept, latch the mode, the effective Nr and the key length.
- Expansion is needed when any of these holds:
  - `in_key_new` = 1;
  - the key cache is invalid;
  - the Nr for `in_keylen` differs from the cached Nr. Keylen 2 and 3 count as identical.
- KEXP behaviour:
  - `key_load` = 1 in the first KEXP cycle only.
  - `key_ready` is sampled from the second KEXP cycle onward.
  - `key_ready` is ignored in every other state.
  - On leaving KEXP, set `cache_valid` and store the cached Nr.
- ROUND behaviour:
  - Round counter k runs 0..Nr, one step per cycle, with `rnd_en` = 1 throughout.
  - `rnd_idx` = k for encrypt, Nr−k for decrypt.
  - `rnd_type` = 0 at k = 0, 2 at k = Nr, 1 otherwise.
- DONE: `out_valid` = 1 and held until `out_ready`. Outputs are stable while waiting.
- `in_ready` = 1 only in IDLE. `in_valid` outside IDLE is ignored and not queued.
- Reset mid-operation: abort to IDLE and clear `cache_valid`. The next job always re-expands.

## Timing
- Reset state (after a clk edge with `rst_n` = 0): IDLE, `cache_valid` = 0, counter = 0.
- Outputs in reset state: `in_ready` = 1; all other outputs 0.
- Let the accept edge be cycle T.
  - Cached key: ROUND occupies T+1..T+1+Nr; `out_valid` first high at T+Nr+2. For AES-128 that is 11 round cycles and `out_valid` at T+12.
  - Expansion: `key_load` at T+1. If `key_ready` is first seen at cycle E ≥ T+2, ROUND starts at E+1.
- `out_ready` high in the first DONE cycle: DONE → IDLE at that edge, and `in_ready` = 1 the next cycle. There is no same-cycle output→input bypass, so there is at most one job in flight.
- `key_ready` already high when KEXP is entered: still wait the one `key_load` cycle (minimum KEXP length 2).
- All outputs are decoded from registered state and counter. No combinational path from any input to any output.

## Structure
- The shared `aes_pkg` holds:
  - the `keylen_t` and `rnd_type_t` enums;
  - the state enum (IDLE, KEXP, ROUND, DONE);
  - the constants NR_128 = 10, NR_192 = 12, NR_256 = 14;
  - the function `nr_of(keylen)`.
- No sub-module. The counter, key cache and FSM live in this single module.

## Test plan
- Reset then a 128-bit encrypt with `in_key_new` = 1, and `key_ready` given 3 cycles after `key_load`:
  - `key_load` appears as a single pulse;
  - then 11 `rnd_en` cycles with `rnd_idx` 0..10 and `rnd_type` sequence 0, 1×9, 2;
  - then `out_valid`.
- Second 128-bit job with `in_key_new` = 0:
  - no `key_load`;
  - `out_valid` exactly 12 cycles after accept.
- 256-bit decrypt (keylen 3) following a cached keylen-2 job:
  - no re-expansion;
  - `rnd_idx` 14 down to 0, `rnd_inv` = 1, `rnd_type` last = 2.
- 192-bit job after a 256-bit cache:
  - expansion is forced;
  - 13 round cycles.
- `out_ready` held low for 5 cycles:
  - `out_valid` and `busy` stay high;
  - `in_ready` = 0 and a concurrent `in_valid` is ignored;
  - release → IDLE.
- `rst_n` = 0 during ROUND at k = 4:
  - next cycle IDLE and all outputs at reset values;
  - the next job pulses `key_load` even with `in_key_new` = 0.
